// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: two store-and-forward frame FIFOs (one per source port)
// merged onto a single valid/ready stream by a round-robin arbiter that
// grants whole frames. Frames that overflow a FIFO are dropped and counted.
module frame_rr_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  input  logic              s0_last,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  input  logic [DATA_W-1:0] s1_data,
  output logic              m_valid,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_src,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  drop_cnt0,
  output logic [CNT_W-1:0]  drop_cnt1,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1, SEND1 = 2'd2} state_t;

  // Each FIFO entry is {last, data}
  logic [DATA_W:0]   r_mem [2][DEPTH];
  logic [PW-1:0]     r_wr  [2];
  logic [PW-1:0]     r_cm  [2];
  logic [PW-1:0]     r_rd  [2];
  logic [1:0]        r_drop;
  logic [CNT_W-1:0]  r_cnt [2];
  state_t            r_state;
  logic              r_last_grant;

  state_t            w_next;
  logic [1:0]        w_s_valid;
  logic [1:0]        w_s_last;
  logic [DATA_W-1:0] w_s_data [2];
  logic [1:0]        w_full;
  logic [1:0]        w_acc;
  logic [1:0]        w_avail;
  logic [1:0]        w_rd_inc;
  logic [DATA_W:0]   w_rd_word [2];

  // Saturating increment for the drop counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign w_s_valid   = {s1_valid, s0_valid};
  assign w_s_last    = {s1_last, s0_last};
  assign w_s_data[0] = s0_data;
  assign w_s_data[1] = s1_data;
  assign drop_cnt0   = r_cnt[0];
  assign drop_cnt1   = r_cnt[1];

  // Per-port status: full uses the read pointer before this cycle's read,
  // so a word arriving on the same edge as a read is judged conservatively.
  always_comb begin
    w_full  = '0;
    w_acc   = '0;
    w_avail = '0;
    for (int k = 0; k < 2; k++) begin
      w_full[k]    = ((r_wr[k] - r_rd[k]) == PW'(DEPTH));
      w_acc[k]     = w_s_valid[k] && !r_drop[k] && !w_full[k];
      w_avail[k]   = (r_cm[k] != r_rd[k]);
      w_rd_word[k] = r_mem[k][r_rd[k][AW-1:0]];
    end
  end

  // FIFO storage: written only for accepted words; contents need no reset
  // because the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && w_acc[k]) begin
        r_mem[k][r_wr[k][AW-1:0]] <= {w_s_last[k], w_s_data[k]};
      end
    end
  end

  // Pointer, drop-mode and drop-counter update per port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_wr[k]  <= '0;
        r_cm[k]  <= '0;
        r_rd[k]  <= '0;
        r_cnt[k] <= '0;
      end
      r_drop <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_rd_inc[k]) begin
          r_rd[k] <= r_rd[k] + PW'(1);
        end
        if (w_s_valid[k]) begin
          if (r_drop[k]) begin
            // Discard the rest of an overflowed frame, through its last word
            if (w_s_last[k]) begin
              r_drop[k] <= 1'b0;
            end
          end else if (!w_full[k]) begin
            r_wr[k] <= r_wr[k] + PW'(1);
            if (w_s_last[k]) begin
              r_cm[k] <= r_wr[k] + PW'(1);
            end
          end else begin
            // Overflow: roll the partial frame back to the last commit point
            r_wr[k]  <= r_cm[k];
            r_cnt[k] <= sat_inc(r_cnt[k]);
            if (!w_s_last[k]) begin
              r_drop[k] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Arbiter state register and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (m_valid && m_ready && m_last) begin
        r_last_grant <= m_src;
      end
    end
  end

  // Next-state: grant whole frames, alternating when both ports are ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_avail[0] && w_avail[1]) begin
          w_next = r_last_grant ? SEND0 : SEND1;
        end else if (w_avail[0]) begin
          w_next = SEND0;
        end else if (w_avail[1]) begin
          w_next = SEND1;
        end
      end
      SEND0: if (m_ready && w_rd_word[0][DATA_W]) w_next = IDLE;
      SEND1: if (m_ready && w_rd_word[1][DATA_W]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: present the head word of the granted FIFO
  always_comb begin
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;
    m_src    = 1'b0;
    w_rd_inc = '0;
    case (r_state)
      SEND0: begin
        m_valid     = 1'b1;
        {m_last, m_data} = w_rd_word[0];
        w_rd_inc[0] = m_ready;
      end
      SEND1: begin
        m_valid     = 1'b1;
        {m_last, m_data} = w_rd_word[1];
        m_src       = 1'b1;
        w_rd_inc[1] = m_ready;
      end
      default: ;
    endcase
    busy = (r_state != IDLE) || (|w_avail);
  end

endmodule
